// File: rtl/multicycle_control.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with memory wait timeout and sticky fault.
// Optional perf counters (cycle_cnt, retired_cnt) are enabled by defining MC_PERF_COUNTERS_EN.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_source,
    output logic       instr_done,
    output logic [1:0] fault,
    output logic [3:0] state_out
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] retired_cnt
`endif
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC      = 4'd6;
    localparam logic [3:0] S_ALU_WB    = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_FAULT     = 4'd9;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_ILLEGAL = 2'b01;
    localparam logic [1:0] F_MEMTO   = 2'b10;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_WIDTH < 1) begin : g_bad_params
        $error("multicycle_control: parameter out of range");
    end

    logic [3:0] state, state_next;
    logic [1:0] fault_next;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       timeout;

    // Memory handshake: the request strobe is held for as long as the state waits, and the
    // access completes on the first cycle mem_ready=1 is seen in that state; a ready in the
    // same cycle as the last allowed wait still counts as completion.
    assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
    assign state_out = state;

    always_comb begin
        state_next = state;
        fault_next = fault;
        case (state)
            S_FETCH:     if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_R, OP_I:   state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    default: begin
                        state_next = S_FAULT;
                        if (fault == F_NONE) fault_next = F_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR:  state_next = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
            S_EXEC:      state_next = S_ALU_WB;
            S_ALU_WB:    state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_FAULT:     state_next = S_FAULT;
            default:     state_next = S_FETCH;
        endcase
        if (timeout) begin
            state_next = S_FAULT;
            if (fault == F_NONE) fault_next = F_MEMTO;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= 8'd0;
            fault    <= F_NONE;
        end else begin
            state <= state_next;
            fault <= fault_next;
            if (state_next != state) begin
                wait_cnt <= 8'd0;
            end else if (mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE:   alu_src_b = 2'b10;
                S_MEM_ADDR: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = 2'b01;
                    alu_op    = 2'b10;
                    alu_src_b = (opcode == OP_R) ? 2'b00 : 2'b10;
                end
                S_ALU_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 2'b01;
                    alu_op     = 2'b01;
                    pc_source  = 1'b1;
                    pc_write   = zero;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_COUNTERS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else begin
            if (state != S_FAULT) cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (instr_done) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected output sequences built from the
// instruction-phase rules, replayed cycle by cycle against the DUT with random don't-care inputs.
module tb_multicycle_control;
    localparam int TO = 4;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [6:0] PCW = 7'b1000000;
    localparam logic [6:0] IRW = 7'b0100000;
    localparam logic [6:0] IOD = 7'b0010000;
    localparam logic [6:0] MRD = 7'b0001000;
    localparam logic [6:0] MWR = 7'b0000100;
    localparam logic [6:0] RW  = 7'b0000010;
    localparam logic [6:0] M2R = 7'b0000001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;
    logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
    logic [1:0] alu_src_a, alu_src_b, alu_op, fault;
    logic pc_source, instr_done;
    logic [3:0] state_out;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_cnt, retired_cnt;
`endif

    always #5 clock = ~clock;

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .instr_done(instr_done), .fault(fault), .state_out(state_out)
`ifdef MC_PERF_COUNTERS_EN
        , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
    );

    // {state[20:17], fault[16:15], pcw,irw,iod,mrd,mwr,rw,m2r [14:8], src_a, src_b, alu_op, pc_source, done}
    logic [20:0] obs;
    assign obs = {state_out, fault, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
                  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};

    logic [20:0] exp_q[$];
    logic [8:0]  stim_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int unsigned exp_cyc = 0;
    int unsigned exp_ret = 0;

    function automatic logic [20:0] ev(input int st, input int flt, input logic [6:0] strb,
                                       input int sa, input int sb, input int aop,
                                       input bit ps, input bit done);
        return {4'(st), 2'(flt), strb, 2'(sa), 2'(sb), 2'(aop), ps, done};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    task automatic push(input logic [6:0] op, input logic z, input logic mr, input logic [20:0] e);
        stim_q.push_back({op, z, mr});
        exp_q.push_back(e);
    endtask

    task automatic fault_fill(input int code);
        repeat (20) push(rop(), rb(), rb(), ev(9, code, 7'b0, 0, 0, 0, 1'b0, 1'b0));
    endtask

    // wf/wm: cycles mem_ready stays low in FETCH / the data access; TO or more means timeout
    task automatic plan_instr(input logic [6:0] op, input logic zv, input int wf, input int wm,
                              output bit faulted);
        int st;
        logic [6:0] s;
        faulted = 1'b0;
        for (int k = 0; k < wf && k < TO; k++) push(rop(), rb(), 1'b0, ev(0, 0, MRD, 0, 1, 0, 0, 0));
        if (wf >= TO) begin
            fault_fill(2);
            faulted = 1'b1;
            return;
        end
        push(rop(), rb(), 1'b1, ev(0, 0, PCW | IRW | MRD, 0, 1, 0, 0, 0));
        push(op, rb(), rb(), ev(1, 0, 7'b0, 0, 2, 0, 0, 0));
        if (op == OP_LW || op == OP_SW) begin
            push(op, rb(), rb(), ev(2, 0, 7'b0, 1, 2, 0, 0, 0));
            st = (op == OP_LW) ? 3 : 5;
            s  = (op == OP_LW) ? (IOD | MRD) : (IOD | MWR);
            for (int k = 0; k < wm && k < TO; k++) push(op, rb(), 1'b0, ev(st, 0, s, 0, 0, 0, 0, 0));
            if (wm >= TO) begin
                fault_fill(2);
                faulted = 1'b1;
                return;
            end
            if (op == OP_LW) begin
                push(op, rb(), 1'b1, ev(3, 0, s, 0, 0, 0, 0, 0));
                push(op, rb(), rb(), ev(4, 0, RW | M2R, 0, 0, 0, 0, 1));
            end else begin
                push(op, rb(), 1'b1, ev(5, 0, s, 0, 0, 0, 0, 1));
            end
        end else if (op == OP_R || op == OP_I) begin
            push(op, rb(), rb(), ev(6, 0, 7'b0, 1, (op == OP_R) ? 0 : 2, 2, 0, 0));
            push(op, rb(), rb(), ev(7, 0, RW, 0, 0, 0, 0, 1));
        end else if (op == OP_BEQ) begin
            push(op, zv, rb(), ev(8, 0, zv ? PCW : 7'b0, 1, 0, 1, 1, 1));
        end else begin
            fault_fill(1);
            faulted = 1'b1;
        end
    endtask

    task automatic run_queue(input string tag);
        logic [8:0]  s;
        logic [20:0] e;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clock);
            reset = 1'b0;
            opcode = s[8:2];
            zero = s[1];
            mem_ready = s[0];
            #1;
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL %s: got %b want %b (state %0d vs %0d) at %0t", tag, obs, e,
                         obs[20:17], e[20:17], $time);
            end
`ifdef MC_PERF_COUNTERS_EN
            n_cmp++;
            if (cycle_cnt !== exp_cyc || retired_cnt !== exp_ret) begin
                n_bad++;
                $display("FAIL %s_counters: got cyc %0d ret %0d want cyc %0d ret %0d", tag,
                         cycle_cnt, retired_cnt, exp_cyc, exp_ret);
            end
`endif
            if (e[20:17] != 4'd9) exp_cyc++;
            if (e[0]) exp_ret++;
        end
    endtask

    // Holds reset for n cycles; strobes and muxes must be 0 throughout regardless of inputs.
    task automatic do_reset(input int n);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            opcode = rop();
            zero = rb();
            mem_ready = 1'b1;
            #1;
            n_cmp++;
            if (obs[14:0] !== 15'b0) begin
                n_bad++;
                $display("FAIL reset_strobes: got %b want 0", obs[14:0]);
            end
            if (i < n - 1) @(negedge clock);
        end
        exp_cyc = 0;
        exp_ret = 0;
    endtask

    task automatic test_reset();
        bit f;
        do_reset(1);
        plan_instr(OP_R, 1'b0, 0, 0, f);
        run_queue("r_type_after_reset");
    endtask

    task automatic test_lw_wait();
        bit f;
        plan_instr(OP_LW, 1'b0, 0, 3, f);
        run_queue("lw_wait3");
        plan_instr(OP_SW, 1'b0, 0, 0, f);
        plan_instr(OP_I, 1'b0, 0, 0, f);
        run_queue("sw_then_i");
    endtask

    task automatic test_branch();
        bit f;
        plan_instr(OP_BEQ, 1'b1, 0, 0, f);
        plan_instr(OP_BEQ, 1'b0, 0, 0, f);
        plan_instr(OP_R, 1'b0, 1, 0, f);
        run_queue("beq");
    endtask

    task automatic test_illegal();
        bit f;
        plan_instr(OP_JAL, 1'b0, 0, 0, f);
        run_queue("illegal_jal");
        do_reset(2);
        plan_instr(OP_I, 1'b0, 0, 0, f);
        run_queue("after_illegal");
    endtask

    task automatic test_timeout();
        bit f;
        plan_instr(OP_R, 1'b0, TO, 0, f);
        run_queue("fetch_timeout");
        do_reset(1);
        plan_instr(OP_R, 1'b0, TO - 1, 0, f);
        run_queue("fetch_ready_last");
        plan_instr(OP_LW, 1'b0, 0, TO, f);
        run_queue("lw_timeout");
        do_reset(1);
        plan_instr(OP_SW, 1'b0, 0, TO - 1, f);
        plan_instr(OP_SW, 1'b0, 0, TO, f);
        run_queue("sw_timeout");
        do_reset(1);
    endtask

    task automatic test_reset_abort();
        bit f;
        push(rop(), rb(), 1'b1, ev(0, 0, PCW | IRW | MRD, 0, 1, 0, 0, 0));
        push(OP_SW, rb(), rb(), ev(1, 0, 7'b0, 0, 2, 0, 0, 0));
        push(OP_SW, rb(), rb(), ev(2, 0, 7'b0, 1, 2, 0, 0, 0));
        push(OP_SW, rb(), 1'b0, ev(5, 0, IOD | MWR, 0, 0, 0, 0, 0));
        run_queue("sw_before_abort");
        do_reset(1);
        plan_instr(OP_R, 1'b0, 0, 0, f);
        run_queue("after_abort");
    endtask

    task automatic test_back_to_back();
        bit f;
        logic [6:0] ops[5];
        ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};
        for (int i = 0; i < 40; i++) begin
            plan_instr(ops[$urandom_range(0, 4)], rb(), $urandom_range(0, TO - 1),
                       $urandom_range(0, TO - 1), f);
        end
        run_queue("random_stream");
    endtask

    initial begin
        test_reset();
        test_lw_wait();
        test_branch();
        test_illegal();
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
